// File: rtl/max_n_pulse_if.sv
// Spike/pulse bundle between column neurons and the temporal max block.
// ch_mask exists only when MAX_N_CH_MASK_EN is defined.
interface max_n_pulse_if #(
  parameter int N_INPUTS          = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16
);
  localparam int IDX_WIDTH =
    (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  logic                         gamma_start;
  logic [N_INPUTS-1:0]          in;
`ifdef MAX_N_CH_MASK_EN
  logic [N_INPUTS-1:0]          ch_mask;
`endif
  logic                         y;
  logic                         y_valid;
  logic [GAMMA_CYCLE_WIDTH-1:0] y_time;
  logic [IDX_WIDTH-1:0]         y_idx;

`ifdef MAX_N_CH_MASK_EN
  modport master (
    output gamma_start, in, ch_mask,
    input  y, y_valid, y_time, y_idx
  );
  modport slave (
    input  gamma_start, in, ch_mask,
    output y, y_valid, y_time, y_idx
  );
`else
  modport master (
    output gamma_start, in,
    input  y, y_valid, y_time, y_idx
  );
  modport slave (
    input  gamma_start, in,
    output y, y_valid, y_time, y_idx
  );
`endif
endinterface

// File: rtl/max_n_pulse.sv
// N-input race-logic temporal max: fires once the last channel spikes.
// Optional MAX_N_CH_MASK_EN adds a per-gamma-cycle channel mask.
module max_n_pulse #(
  parameter int N_INPUTS          = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input logic          aclk,
  input logic          grst_n,
  max_n_pulse_if.slave bus
);
  localparam int IDX_WIDTH =
    (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int CW =
    (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam int GW = GAMMA_CYCLE_WIDTH;

  logic [N_INPUTS-1:0]  prev_in;
  logic [N_INPUTS-1:0]  arrived;
  logic [N_INPUTS-1:0]  arr_cur;
  logic [N_INPUTS-1:0]  rise;
  logic [N_INPUTS-1:0]  cand;
  logic [N_INPUTS-1:0]  mask_cur;
  logic                 started;
  logic                 gs;
  logic                 fired;
  logic                 fired_cur;
  logic                 fire_now;
  logic [GW-1:0]        t;
  logic [GW-1:0]        t_cur;
  logic [GW-1:0]        t_nxt;
  logic [CW-1:0]        pulse_cnt;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 y_q;
  logic                 y_valid_q;
  logic [GW-1:0]        y_time_q;
  logic [IDX_WIDTH-1:0] y_idx_q;

  // first cycle after reset release starts a gamma cycle
  assign gs = bus.gamma_start | ~started;

`ifdef MAX_N_CH_MASK_EN
  logic [N_INPUTS-1:0] mask_q;

  assign mask_cur = gs ? bus.ch_mask : mask_q;

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) mask_q <= '0;
    else         mask_q <= mask_cur;
  end
`else
  assign mask_cur = '1;
`endif

  always_comb begin
    rise      = bus.in & ~prev_in;
    arr_cur   = gs ? '0 : arrived;
    fired_cur = gs ? 1'b0 : fired;
    t_cur     = gs ? '0 : t;
    t_nxt     = (&t_cur) ? t_cur
                         : t_cur + GW'(1);
    cand      = rise & mask_cur;
    fire_now  = (&(arr_cur | rise | ~mask_cur))
              & ~fired_cur & (|cand);
    win_idx   = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = IDX_WIDTH'(i);
    end
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      started   <= 1'b0;
      prev_in   <= '0;
      arrived   <= '0;
      fired     <= 1'b0;
      t         <= '0;
      pulse_cnt <= '0;
      y_q       <= 1'b0;
      y_valid_q <= 1'b0;
      y_time_q  <= '0;
      y_idx_q   <= '0;
    end else begin
      started   <= 1'b1;
      prev_in   <= bus.in;
      arrived   <= arr_cur | rise;
      fired     <= fired_cur | fire_now;
      t         <= t_nxt;
      y_valid_q <= fire_now;
      if (fire_now) begin
        y_q       <= 1'b1;
        pulse_cnt <= CW'(PULSE_WIDTH - 1);
        y_time_q  <= t_cur;
        y_idx_q   <= win_idx;
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - CW'(1);
      end else begin
        y_q <= 1'b0;
      end
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_time  = y_time_q;
  assign bus.y_idx   = y_idx_q;
endmodule

// File: tb/tb_max_n_pulse.sv
// Directed bench for max_n_pulse (16-bit and saturating 4-bit t).
// Mask steps run only with MAX_N_CH_MASK_EN defined.
module tb_max_n_pulse;
  logic aclk;
  logic grst_n;
  int   ncmp;
  int   nfail;
  int   vcnt;
  int   vcnt2;
  int   vat;
  int   ycnt;

  max_n_pulse_if #(
    .N_INPUTS(4), .GAMMA_CYCLE_WIDTH(16)
  ) bus1 ();
  max_n_pulse_if #(
    .N_INPUTS(4), .GAMMA_CYCLE_WIDTH(4)
  ) bus2 ();

  assign bus2.gamma_start = bus1.gamma_start;
  assign bus2.in          = bus1.in;
`ifdef MAX_N_CH_MASK_EN
  assign bus2.ch_mask     = bus1.ch_mask;
`endif

  max_n_pulse #(
    .N_INPUTS(4),
    .GAMMA_CYCLE_WIDTH(16),
    .PULSE_WIDTH(8)
  ) dut1 (
    .aclk(aclk), .grst_n(grst_n), .bus(bus1.slave)
  );

  max_n_pulse #(
    .N_INPUTS(4),
    .GAMMA_CYCLE_WIDTH(4),
    .PULSE_WIDTH(8)
  ) dut2 (
    .aclk(aclk), .grst_n(grst_n), .bus(bus2.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    ncmp  = 0;
    nfail = 0;
    grst_n = 1'b0;
    bus1.gamma_start = 1'b0;
    bus1.in = '0;
`ifdef MAX_N_CH_MASK_EN
    bus1.ch_mask = 4'b1111;
`endif
    #12;
    chk("rst_y",      32'(bus1.y), 0);
    chk("rst_yvalid", 32'(bus1.y_valid), 0);
    chk("rst_ytime",  32'(bus1.y_time), 0);
    chk("rst_yidx",   32'(bus1.y_idx), 0);
    @(negedge aclk);
    grst_n = 1'b1;
    cyc(); cyc(); cyc();

    // basic: last arrival ch3 at offset 10
    for (int c = 0; c < 24; c++) begin
      bus1.gamma_start = (c == 0);
      if (c == 3)  bus1.in[0] = 1'b1;
      if (c == 5)  bus1.in[2] = 1'b1;
      if (c == 7)  bus1.in[1] = 1'b1;
      if (c == 10) bus1.in[3] = 1'b1;
      cyc();
      chk("t1_yvalid", 32'(bus1.y_valid),
          32'(c + 1 == 11));
      chk("t1_y", 32'(bus1.y),
          32'(c + 1 >= 11 && c + 1 <= 18));
    end
    chk("t1_ytime", 32'(bus1.y_time), 10);
    chk("t1_yidx",  32'(bus1.y_idx), 3);
    chk("t1_ytime_w4", 32'(bus2.y_time), 10);

    // incomplete cycle, then held-high inputs
    bus1.in = '0;
    cyc(); cyc();
    ycnt = 0;
    for (int c = 0; c < 121; c++) begin
      bus1.gamma_start = (c == 0 || c == 100);
      if (c == 2)   bus1.in[0] = 1'b1;
      if (c == 4)   bus1.in[1] = 1'b1;
      if (c == 6)   bus1.in[2] = 1'b1;
      if (c == 103) bus1.in[3] = 1'b1;
      cyc();
      if (bus1.y !== 1'b0) ycnt++;
    end
    chk("t2_y_quiet", 32'(ycnt), 0);
    chk("t2_ytime_held", 32'(bus1.y_time), 10);

    // tie on final cycle, ignored repeat, saturation
    bus1.in = '0;
    cyc(); cyc();
    vcnt = 0; vcnt2 = 0; vat = -1;
    for (int c = 0; c < 40; c++) begin
      bus1.gamma_start = (c == 0);
      if (c == 2)  bus1.in[0] = 1'b1;
      if (c == 4)  bus1.in[0] = 1'b0;
      if (c == 8)  bus1.in[2] = 1'b1;
      if (c == 15) bus1.in[0] = 1'b1;
      if (c == 20) bus1.in[3:1] = 3'b111;
      cyc();
      if (bus1.y_valid === 1'b1) begin
        vcnt++;
        vat = c + 1;
      end
      if (bus2.y_valid === 1'b1) vcnt2++;
    end
    chk("t3_vcnt", 32'(vcnt), 1);
    chk("t3_vat",  32'(vat), 21);
    chk("t3_ytime", 32'(bus1.y_time), 20);
    chk("t3_yidx",  32'(bus1.y_idx), 1);
    chk("t3_vcnt_w4", 32'(vcnt2), 1);
    chk("t3_ytime_sat", 32'(bus2.y_time), 15);
    chk("t3_yidx_w4",   32'(bus2.y_idx), 1);

    // all rise with gamma_start, then async reset
    bus1.in = '0;
    cyc(); cyc(); cyc();
    bus1.gamma_start = 1'b1;
    bus1.in = '1;
    cyc();
    bus1.gamma_start = 1'b0;
    chk("t4_yvalid", 32'(bus1.y_valid), 1);
    chk("t4_y",      32'(bus1.y), 1);
    chk("t4_ytime",  32'(bus1.y_time), 0);
    chk("t4_yidx",   32'(bus1.y_idx), 0);
    cyc(); cyc(); cyc();
    chk("t4_y_mid",  32'(bus1.y), 1);
    #1 grst_n = 1'b0;
    #1;
    chk("t4_rst_y",      32'(bus1.y), 0);
    chk("t4_rst_yvalid", 32'(bus1.y_valid), 0);
    chk("t4_rst_ytime",  32'(bus1.y_time), 0);
    chk("t4_rst_yidx",   32'(bus1.y_idx), 0);

    // release with inputs high acts as gamma_start
    @(negedge aclk);
    grst_n = 1'b1;
    cyc();
    chk("t4_rel_yvalid", 32'(bus1.y_valid), 1);
    chk("t4_rel_ytime",  32'(bus1.y_time), 0);
    bus1.in = '0;
    for (int c = 0; c < 10; c++) cyc();
    chk("t4_rel_yend", 32'(bus1.y), 0);

    // refire during an active pulse
    for (int c = 0; c < 20; c++) begin
      bus1.gamma_start = (c == 0 || c == 4);
      if (c == 0 || c == 4) bus1.in = '1;
      if (c == 2 || c == 6) bus1.in = '0;
      cyc();
      chk("t5_yvalid", 32'(bus1.y_valid),
          32'(c + 1 == 1 || c + 1 == 5));
      chk("t5_y", 32'(bus1.y),
          32'(c + 1 >= 1 && c + 1 <= 12));
    end

`ifdef MAX_N_CH_MASK_EN
    bus1.in = '0;
    cyc(); cyc(); cyc();
    vcnt = 0; vat = -1;
    for (int c = 0; c < 16; c++) begin
      bus1.gamma_start = (c == 0);
      if (c == 0) bus1.ch_mask = 4'b0101;
      if (c == 1) begin
        bus1.ch_mask = 4'b1111;
        bus1.in[1] = 1'b1;
      end
      if (c == 4) bus1.in[0] = 1'b1;
      if (c == 6) bus1.in[2] = 1'b1;
      if (c == 9) bus1.in[3] = 1'b1;
      cyc();
      if (bus1.y_valid === 1'b1) begin
        vcnt++;
        vat = c + 1;
      end
    end
    chk("m1_vcnt",  32'(vcnt), 1);
    chk("m1_vat",   32'(vat), 7);
    chk("m1_yidx",  32'(bus1.y_idx), 2);
    chk("m1_ytime", 32'(bus1.y_time), 6);

    bus1.in = '0;
    cyc(); cyc(); cyc();
    vcnt = 0;
    for (int c = 0; c < 16; c++) begin
      bus1.gamma_start = (c == 0);
      if (c == 0) bus1.ch_mask = 4'b0000;
      if (c == 1) bus1.ch_mask = 4'b1111;
      if (c == 2) bus1.in = '1;
      cyc();
      if (bus1.y_valid === 1'b1) vcnt++;
    end
    chk("m2_vcnt", 32'(vcnt), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/max_n_pulse.md
Name: max_n_pulse

Overview:
- N-input generalisation of the pulse-coded temporal max operator for the race-logic datapath.
- Within one gamma cycle, each input carries at most one spike, coded as the rising edge of its pulse. The block emits one output pulse of PULSE_WIDTH cycles, timed by the latest-arriving input.
- Additionally reports the arrival time and the index of the winning (last) channel.
- Sits between column neurons and the WTA/inhibition stage. gamma_start is driven by the shared gamma sequencer.

Parameters:
- N_INPUTS, 4, number of spike inputs (>=2).
- GAMMA_CYCLE_WIDTH, 16, width of the in-cycle time counter and of y_time.
- PULSE_WIDTH, 8, output pulse length in aclk cycles (>=1).
- IDX_WIDTH (localparam), max(1,$clog2(N_INPUTS)), width of y_idx.

Ports:
- aclk  input  1  clock; single clock domain.
- grst_n  input  1  asynchronous, active-low reset.
- gamma_start  input  1  one-cycle strobe marking the first cycle of a new gamma cycle.
- in  input  N_INPUTS  spike pulses; all synchronous to aclk.
- y  output  1  max output pulse.
- y_valid  output  1  one-cycle strobe, coincident with the first cycle of y.
- y_time  output  GAMMA_CYCLE_WIDTH  cycle offset, from gamma start, of the last arrival; held until the next fire.
- y_idx  output  IDX_WIDTH  channel that arrived last; held until the next fire.

Behaviour:
- Reset (grst_n=0, async assert, sync release): y=0, y_valid=0, y_time=0, y_idx=0; prev_in=0, arrived=0, fired=0, t=0, pulse_cnt=0.
  - Reset release behaves as if gamma_start occurred in the release cycle.
- Edge detect: rise[i] = in[i] & ~prev_in[i]; prev_in is registered every cycle.
- Arrival tracking: sticky arrived[i] is set on rise[i].
  - A second rise on an already-arrived channel in the same gamma cycle is ignored.
- Time counter t:
  - Cleared to 0 in the gamma_start cycle; +1 every other cycle.
  - Saturates at 2^GAMMA_CYCLE_WIDTH-1.
  - t is the offset of the current cycle.
- Fire condition (combinational, cycle k): (arrived | rise) == all-ones, fired==0, and rise != 0.
- Fire action (registered, visible cycle k+1, latency 1 cycle from the final input edge):
  - y=1 and y_valid=1.
  - y_time = t at cycle k.
  - y_idx = lowest index i with rise[i]=1 at cycle k; a tie on the final cycle resolves to the lowest index.
  - fired=1; pulse_cnt loads PULSE_WIDTH-1.
- Pulse: y stays 1 for exactly PULSE_WIDTH cycles (pulse_cnt counts down to 0), then returns to 0. y_valid is high only in the first cycle.
- Incomplete cycle: if any channel never rises before the next gamma_start, there is no output for that gamma cycle (max = infinity).
- gamma_start handling:
  - Clears arrived, fired and t.
  - A rise in the same cycle as gamma_start counts as an arrival in the new gamma cycle at t=0.
  - An all-inputs-rise in the gamma_start cycle fires with y_time=0.
- gamma_start during an active pulse:
  - The pulse is not truncated.
  - If a new fire occurs before the pulse ends, pulse_cnt reloads and y_valid pulses again; y stays high continuously.
- Saturated t: arrivals still count, and y_time reports the saturated value.
- Inputs held high across gamma_start do not produce a new rise in the new cycle.
- Mid-operation reset: all state returns to reset values immediately, and any pulse in progress is aborted.

Optional Feature:
- Macro: MAX_N_CH_MASK_EN.
- Defined:
  - Adds input port ch_mask [N_INPUTS-1:0] (1 = channel participates).
  - The mask is registered in the gamma_start cycle (and at reset release, where it captures ch_mask) and held for the gamma cycle.
  - Masked-off channels are treated as already arrived and never win y_idx.
  - An all-zero registered mask: the block never fires in that gamma cycle.
- Undefined: port absent; all channels participate.

Test Plan:
- N=4, gamma_start @cycle0; rises on ch0@3, ch2@5, ch1@7, ch3@10 -> y_valid and y=1 @11; y high cycles 11..18 (PULSE_WIDTH=8); y_time=10, y_idx=3.
- ch0..ch2 rise, ch3 silent, next gamma_start @100 -> y stays 0 for the whole cycle; arrived clears @100.
- ch1 and ch3 rise together last @20 -> y_idx=1, y_time=20; a repeat rise on ch0 @15 is ignored, so exactly one y_valid.
- All four rise in the gamma_start cycle @200 -> y_valid @201, y_time=0; grst_n low @204 -> y=0 immediately and all outputs 0.
- GAMMA_CYCLE_WIDTH=4: last arrival @offset 20 -> y_time=15 (saturated).
- MAX_N_CH_MASK_EN defined:
  - ch_mask=4'b0101 at gamma_start; ch0@4, ch2@6 -> fire @7 with y_idx=2; ch1/ch3 activity is ignored.
  - ch_mask=0 at gamma_start -> no fire.
